// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared func encodings, FSM states and instruction field positions for alu_sequencer.
package alu_seq_pkg;

    localparam logic [1:0] FUNC_ADD = 2'b00;
    localparam logic [1:0] FUNC_MUL = 2'b01;
    localparam logic [1:0] FUNC_AND = 2'b10;
    localparam logic [1:0] FUNC_MAC = 2'b11;

    localparam int F_MSB   = 1;
    localparam int F_LSB   = 0;
    localparam int A_MSB   = 9;
    localparam int A_LSB   = 6;
    localparam int B_MSB   = 5;
    localparam int B_LSB   = 2;
    localparam int M1A_MSB = 9;
    localparam int M1A_LSB = 8;
    localparam int M1B_MSB = 7;
    localparam int M1B_LSB = 6;
    localparam int M2A_MSB = 5;
    localparam int M2A_LSB = 4;
    localparam int M2B_MSB = 3;
    localparam int M2B_LSB = 2;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_OUT, S_DONE} state_t;

    function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
        return {2'b00, x} * {2'b00, y};
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational 4-bit ALU (add / 2-bit multiply / and / multiply-add) decoding one instruction word.
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int RES_W = 5
) (
    input  logic [9:0]       instr,
    output logic [RES_W-1:0] res
);

    logic [1:0] func;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] p_hi;
    logic [3:0] p_lo;

    assign func = instr[F_MSB:F_LSB];
    assign a    = instr[A_MSB:A_LSB];
    assign b    = instr[B_MSB:B_LSB];
    assign p_hi = mul2(instr[M1A_MSB:M1A_LSB], instr[M1B_MSB:M1B_LSB]);
    assign p_lo = mul2(instr[M2A_MSB:M2A_LSB], instr[M2B_MSB:M2B_LSB]);

    assign res = (func == FUNC_ADD) ? RES_W'({1'b0, a} + {1'b0, b}) :
                 (func == FUNC_MUL) ? RES_W'(p_hi) :
                 (func == FUNC_AND) ? RES_W'(a & b) :
                                      RES_W'({1'b0, p_hi} + {1'b0, p_lo});

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches prog_len instruction words from address 0, runs them through alu_core, returns results over valid/ready.
// Optional macro ALU_SEQ_STALL_STATS_EN builds the saturating backpressure counter behind stall_cnt.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int RES_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [9:0]        imem_rdata,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [1:0]        res_func,
    output logic [ADDR_W-1:0] res_addr,
    output logic              busy,
    output logic              done,
    output logic [7:0]        stall_cnt
);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [9:0]        instr_q;
    logic              rd_en_q;
    logic              valid_q;
    logic              done_q;
    logic [RES_W-1:0]  data_q;
    logic [1:0]        func_q;
    logic [ADDR_W-1:0] addr_q;
    logic [RES_W-1:0]  alu_res;
    logic              last;

    alu_core #(.RES_W(RES_W)) u_core (
        .instr (instr_q),
        .res   (alu_res)
    );

    assign last = ({1'b0, pc_q} == prog_len - (ADDR_W + 1)'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            func_q  <= '0;
            addr_q  <= '0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    pc_q <= '0;
                    if (prog_len == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_FETCH;
                        rd_en_q <= 1'b1;
                    end
                end
                S_FETCH: state_q <= S_WAIT;
                S_WAIT: begin
                    instr_q <= imem_rdata;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    data_q  <= alu_res;
                    func_q  <= instr_q[F_MSB:F_LSB];
                    addr_q  <= pc_q;
                    valid_q <= 1'b1;
                    state_q <= S_OUT;
                end
                S_OUT: if (res_ready) begin
                    valid_q <= 1'b0;
                    if (last) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        pc_q    <= pc_q + ADDR_W'(1);
                        state_q <= S_FETCH;
                        rd_en_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem_rd_en = rd_en_q;
    assign imem_addr  = pc_q;
    assign res_valid  = valid_q;
    assign res_data   = data_q;
    assign res_func   = func_q;
    assign res_addr   = addr_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

`ifdef ALU_SEQ_STALL_STATS_EN
    logic [7:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n || (state_q == S_IDLE && start))
            stall_q <= '0;
        else if (state_q == S_OUT && !res_ready && stall_q != 8'hff)
            stall_q <= stall_q + 8'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
